// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 raster timing generator.
// Issues pixel coordinates to the sprite layers. Takes their combined pixel
// back one cycle later and outputs registered RGB with matching sync pulses.
module vga_scan #(
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter logic [11:0] FG_COLOR = 12'h000,
  parameter logic [11:0] BG_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        px_in,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        video_on,
  output logic        fresh,
  output logic        hs_n,
  output logic        vs_n,
  output logic [11:0] rgb,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;

  // Raster position and frame count
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [15:0] frame_q, frame_d;

  // Stage 1: decode of the current raster position
  logic        von_q, von_d;
  logic [9:0]  col_q, col_d;
  logic [8:0]  row_q, row_d;
  logic        fresh_q, fresh_d;
  logic        hs_raw_q, hs_raw_d;
  logic        vs_raw_q, vs_raw_d;

  // Stage 2: sync and colour, aligned with the layers' registered pixel
  logic        hs_n_q, hs_n_d;
  logic        vs_n_q, vs_n_d;
  logic [11:0] rgb_q, rgb_d;

  logic h_wrap, v_wrap, h_vis, v_vis;

  // Next-state for counters, decode stage and output stage
  always_comb begin
    h_wrap  = (h_q == 10'(H_TOTAL - 1));
    v_wrap  = (v_q == 10'(V_TOTAL - 1));
    h_d     = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d     = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    end
    frame_d = (h_wrap && v_wrap) ? frame_q + 16'd1 : frame_q;

    h_vis   = (h_q >= 10'(HA0)) && (h_q < 10'(HA0 + H_ACTIVE));
    v_vis   = (v_q >= 10'(VA0)) && (v_q < 10'(VA0 + V_ACTIVE));
    von_d   = h_vis && v_vis;
    // Offsets are taken only inside the window, so they never go negative;
    // the row offset is computed modulo 512, which is exact for 0..479.
    col_d   = von_d ? (h_q - 10'(HA0)) : 10'd0;
    row_d   = von_d ? (v_q[8:0] - 9'(VA0)) : 9'd0;
    fresh_d = (v_q >= 10'(VA0 + V_ACTIVE));
    hs_raw_d = !(h_q < 10'(H_SYNC));
    vs_raw_d = !(v_q < 10'(V_SYNC));

    hs_n_d  = hs_raw_q;
    vs_n_d  = vs_raw_q;
    rgb_d   = von_q ? (px_in ? FG_COLOR : BG_COLOR) : 12'h000;
  end

  // All state registers; raw syncs reset inactive so hs_n/vs_n stay high
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      frame_q  <= 16'd0;
      von_q    <= 1'b0;
      col_q    <= 10'd0;
      row_q    <= 9'd0;
      fresh_q  <= 1'b0;
      hs_raw_q <= 1'b1;
      vs_raw_q <= 1'b1;
      hs_n_q   <= 1'b1;
      vs_n_q   <= 1'b1;
      rgb_q    <= 12'h000;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      frame_q  <= frame_d;
      von_q    <= von_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fresh_q  <= fresh_d;
      hs_raw_q <= hs_raw_d;
      vs_raw_q <= vs_raw_d;
      hs_n_q   <= hs_n_d;
      vs_n_q   <= vs_n_d;
      rgb_q    <= rgb_d;
    end
  end

  assign row_addr  = row_q;
  assign col_addr  = col_q;
  assign video_on  = von_q;
  assign fresh     = fresh_q;
  assign hs_n      = hs_n_q;
  assign vs_n      = vs_n_q;
  assign rgb       = rgb_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: directed test of vga_scan. One instance uses a shortened
// vertical timing (11 lines/frame) so whole frames fit in the run; a second
// instance uses the full 800x525 timing for the first-pixel position.
module tb_vga_scan;

  logic        clk;
  logic        RESET_N;
  logic        px_in;

  logic [8:0]  s_row, f_row;
  logic [9:0]  s_col, f_col;
  logic        s_von, f_von, s_fresh, f_fresh;
  logic        s_hs_n, f_hs_n, s_vs_n, f_vs_n;
  logic [11:0] s_rgb, f_rgb;
  logic [15:0] s_frame, f_frame;

  int checks = 0;
  int errors = 0;
  int n = 0;          // posedges since the last reset release
  int hs_fall = 0;

  // Small frame: VA0 = 5, visible lines 5..8, fresh lines 9..10, 8800 clks
  vga_scan #(.V_SYNC(2), .V_BP(3), .V_ACTIVE(4), .V_FP(2)) dut_small (
    .clk(clk), .RESET_N(RESET_N), .px_in(px_in),
    .row_addr(s_row), .col_addr(s_col), .video_on(s_von), .fresh(s_fresh),
    .hs_n(s_hs_n), .vs_n(s_vs_n), .rgb(s_rgb), .frame_cnt(s_frame)
  );

  vga_scan dut_full (
    .clk(clk), .RESET_N(RESET_N), .px_in(px_in),
    .row_addr(f_row), .col_addr(f_col), .video_on(f_von), .fresh(f_fresh),
    .hs_n(f_hs_n), .vs_n(f_vs_n), .rgb(f_rgb), .frame_cnt(f_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    px_in   = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (s_hs_n !== 1'b1) begin errors++; $display("FAIL reset_hs_n got %b want 1", s_hs_n); end
    checks++; if (s_vs_n !== 1'b1) begin errors++; $display("FAIL reset_vs_n got %b want 1", s_vs_n); end
    checks++; if (s_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", s_rgb); end
    checks++; if (s_von !== 1'b0) begin errors++; $display("FAIL reset_video_on got %b want 0", s_von); end
    checks++; if (s_fresh !== 1'b0) begin errors++; $display("FAIL reset_fresh got %b want 0", s_fresh); end
    checks++; if (s_frame !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", s_frame); end
    checks++; if (s_row !== 9'd0 || s_col !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d,%0d want 0,0", s_row, s_col); end
    @(negedge clk);
    RESET_N = 1'b1;
    n = 0;
    step();
    checks++; if (s_hs_n !== 1'b1) begin errors++; $display("FAIL edge1_hs_n got %b want 1", s_hs_n); end
    step();
    checks++; if (s_hs_n !== 1'b0) begin errors++; $display("FAIL edge2_hs_n got %b want 0", s_hs_n); end
    checks++; if (s_vs_n !== 1'b0) begin errors++; $display("FAIL edge2_vs_n got %b want 0", s_vs_n); end
    $display("test_reset done at edge %0d", n);
  endtask

  task automatic test_horizontal();
    int low_cnt;
    low_cnt = 1;
    for (int i = 0; i < 2000 && s_hs_n === 1'b0; i++) begin
      step();
      if (s_hs_n === 1'b0) low_cnt++;
    end
    checks++; if (low_cnt != 96) begin errors++; $display("FAIL hs_low_width got %0d want 96", low_cnt); end
    for (int i = 0; i < 2000 && s_hs_n !== 1'b0; i++) step();
    checks++; if (n != 802) begin errors++; $display("FAIL hs_period next fall at edge %0d want 802", n); end
    hs_fall = n;
    $display("test_horizontal hs low %0d clks, next fall edge %0d", low_cnt, n);
  endtask

  task automatic test_active_line();
    logic px;
    px_in = 1'b1;
    for (int i = 0; i < 10000 && s_von !== 1'b1; i++) step();
    checks++; if (n != 4145) begin errors++; $display("FAIL first_visible edge got %0d want 4145", n); end
    checks++; if (s_row !== 9'd0 || s_col !== 10'd0) begin errors++; $display("FAIL first_visible_addr got %0d,%0d want 0,0", s_row, s_col); end
    checks++; if (s_rgb !== 12'h000) begin errors++; $display("FAIL blank_mask_rgb got %h want 000", s_rgb); end
    for (int i = 1; i <= 640; i++) begin
      px = ((i % 7) < 3);
      px_in = px;
      step();
      if (i < 640) begin
        checks++;
        if (s_von !== 1'b1 || s_col !== 10'(i) || s_row !== 9'd0) begin
          errors++; $display("FAIL line_col von=%b col=%0d row=%0d want 1,%0d,0", s_von, s_col, s_row, i);
        end
      end
      checks++;
      if (s_rgb !== (px ? 12'h000 : 12'hFFF)) begin
        errors++; $display("FAIL line_rgb col %0d got %h want %h", i - 1, s_rgb, px ? 12'h000 : 12'hFFF);
      end
      if (i == 1) begin
        checks++; if (n - hs_fall != 144 + 4 * 800) begin errors++; $display("FAIL hs_rgb_align offset got %0d want %0d", n - hs_fall, 144 + 4 * 800); end
      end
    end
    checks++; if (s_von !== 1'b0 || s_col !== 10'd0) begin errors++; $display("FAIL line_end von=%b col=%0d want 0,0", s_von, s_col); end
    px_in = 1'b1;
    step();
    checks++; if (s_rgb !== 12'h000) begin errors++; $display("FAIL hblank_rgb got %h want 000", s_rgb); end
    $display("test_active_line done at edge %0d", n);
  endtask

  task automatic test_last_pixel();
    while (n < 7184) step();
    checks++; if (s_von !== 1'b1 || s_row !== 9'd3 || s_col !== 10'd639) begin
      errors++; $display("FAIL last_pixel von=%b row=%0d col=%0d want 1,3,639", s_von, s_row, s_col);
    end
    step();
    checks++; if (s_von !== 1'b0 || s_row !== 9'd0 || s_col !== 10'd0) begin
      errors++; $display("FAIL after_last von=%b row=%0d col=%0d want 0,0,0", s_von, s_row, s_col);
    end
    $display("test_last_pixel done at edge %0d", n);
  endtask

  task automatic test_vertical();
    int cnt;
    for (int i = 0; i < 20000 && s_fresh !== 1'b1; i++) step();
    checks++; if (n != 7201) begin errors++; $display("FAIL fresh_rise edge got %0d want 7201", n); end
    cnt = 1;
    for (int i = 0; i < 20000 && s_fresh === 1'b1; i++) begin
      step();
      if (s_fresh === 1'b1) cnt++;
    end
    checks++; if (cnt != 1600) begin errors++; $display("FAIL fresh_width got %0d want 1600", cnt); end
    checks++; if (n != 8801) begin errors++; $display("FAIL fresh_fall edge got %0d want 8801", n); end
    checks++; if (s_frame !== 16'd1) begin errors++; $display("FAIL frame_cnt_1 got %0d want 1", s_frame); end
    for (int i = 0; i < 20000 && s_vs_n !== 1'b0; i++) step();
    checks++; if (n != 8802) begin errors++; $display("FAIL vs_period fall edge got %0d want 8802", n); end
    cnt = 1;
    for (int i = 0; i < 20000 && s_vs_n === 1'b0; i++) begin
      step();
      if (s_vs_n === 1'b0) cnt++;
    end
    checks++; if (cnt != 1600) begin errors++; $display("FAIL vs_low_width got %0d want 1600", cnt); end
    $display("test_vertical done at edge %0d", n);
  endtask

  task automatic test_frame_count();
    while (n < 17599) step();
    checks++; if (s_frame !== 16'd1) begin errors++; $display("FAIL frame_cnt_pre got %0d want 1", s_frame); end
    step();
    checks++; if (s_frame !== 16'd2) begin errors++; $display("FAIL frame_cnt_2 got %0d want 2", s_frame); end
    $display("test_frame_count frame_cnt %0d at edge %0d", s_frame, n);
  endtask

  task automatic test_full_timing();
    while (n < 28144) step();
    checks++; if (f_von !== 1'b0 || f_fresh !== 1'b0 || f_frame !== 16'd0) begin
      errors++; $display("FAIL full_pre von=%b fresh=%b frame=%0d want 0,0,0", f_von, f_fresh, f_frame);
    end
    step();
    checks++; if (f_von !== 1'b1 || f_row !== 9'd0 || f_col !== 10'd0) begin
      errors++; $display("FAIL full_first_pixel von=%b row=%0d col=%0d want 1,0,0", f_von, f_row, f_col);
    end
    $display("test_full_timing first pixel at edge %0d", n);
  endtask

  task automatic test_midframe_reset();
    checks++; if (s_frame !== 16'd3) begin errors++; $display("FAIL frame_cnt_3 got %0d want 3", s_frame); end
    px_in = 1'b1;
    RESET_N = 1'b0;
    #1;
    checks++; if (f_von !== 1'b0 || f_row !== 9'd0 || f_col !== 10'd0) begin
      errors++; $display("FAIL async_addr von=%b row=%0d col=%0d want 0,0,0", f_von, f_row, f_col);
    end
    checks++; if (f_hs_n !== 1'b1 || f_vs_n !== 1'b1 || f_rgb !== 12'h000) begin
      errors++; $display("FAIL async_out hs=%b vs=%b rgb=%h want 1,1,000", f_hs_n, f_vs_n, f_rgb);
    end
    checks++; if (s_frame !== 16'd0 || s_fresh !== 1'b0) begin
      errors++; $display("FAIL async_frame frame=%0d fresh=%b want 0,0", s_frame, s_fresh);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    RESET_N = 1'b1;
    n = 0;
    step();
    checks++; if (f_vs_n !== 1'b1) begin errors++; $display("FAIL restart_edge1_vs got %b want 1", f_vs_n); end
    step();
    checks++; if (f_vs_n !== 1'b0 || f_hs_n !== 1'b0) begin
      errors++; $display("FAIL restart_edge2 vs=%b hs=%b want 0,0", f_vs_n, f_hs_n);
    end
    checks++; if (f_frame !== 16'd0 || s_frame !== 16'd0) begin
      errors++; $display("FAIL restart_frame full=%0d small=%0d want 0,0", f_frame, s_frame);
    end
    $display("test_midframe_reset restart checked at edge %0d", n);
  endtask

  initial begin
    RESET_N = 1'b0;
    px_in   = 1'b1;
    test_reset();
    test_horizontal();
    test_active_line();
    test_last_pixel();
    test_vertical();
    test_frame_count();
    test_full_timing();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
